// File: rtl/act_line_buffer.sv
// Raster-order activation streamer: keeps the two previous image rows in line
// memories and emits vertically aligned pixel triples for a 3x3 patch register file.
module act_line_buffer #(
   parameter int DATA_WIDTH    = 16,
   parameter int IMG_WIDTH_MAX = 224,
   parameter int ADDR_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     img_width,
   input  logic [ADDR_W-1:0]     img_height,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_WIDTH-1:0] pix_data,
   input  logic                  out_ready,
   output logic                  act_load,
   output logic [DATA_WIDTH-1:0] data_first_row,
   output logic [DATA_WIDTH-1:0] data_second_row,
   output logic [DATA_WIDTH-1:0] data_third_row,
   output logic                  patch_valid,
   output logic [ADDR_W-1:0]     patch_row,
   output logic [ADDR_W-1:0]     patch_col,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   localparam int                COL_AW = (IMG_WIDTH_MAX > 1) ? $clog2(IMG_WIDTH_MAX) : 1;
   localparam logic [ADDR_W-1:0] W_MAX  = ADDR_W'(IMG_WIDTH_MAX);
   localparam logic [ADDR_W-1:0] MIN_SZ = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_W-1:0]     r_width;
   logic [ADDR_W-1:0]     r_height;
   logic [ADDR_W-1:0]     r_col;
   logic [ADDR_W-1:0]     r_row;
   logic [ADDR_W-1:0]     r_load_row;
   logic [ADDR_W-1:0]     r_load_col;
   logic                  r_act_load;
   logic                  r_patch_valid;
   logic [ADDR_W-1:0]     r_patch_row;
   logic [ADDR_W-1:0]     r_patch_col;
   logic [DATA_WIDTH-1:0] r_first_row;
   logic [DATA_WIDTH-1:0] r_second_row;
   logic [DATA_WIDTH-1:0] r_third_row;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_cfg_err;

   logic [DATA_WIDTH-1:0] r_line0 [0:IMG_WIDTH_MAX-1];
   logic [DATA_WIDTH-1:0] r_line1 [0:IMG_WIDTH_MAX-1];

   logic                  w_accept;
   logic                  w_last_col;
   logic                  w_last_row;
   logic                  w_size_ok;
   logic [COL_AW-1:0]     w_col_idx;
   logic [DATA_WIDTH-1:0] w_line0_rd;
   logic [DATA_WIDTH-1:0] w_line1_rd;

   assign pix_ready  = (r_state == S_RUN) && out_ready;
   assign w_accept   = pix_valid && pix_ready;
   assign w_last_col = (r_col == (r_width - ONE));
   assign w_last_row = (r_row == (r_height - ONE));
   assign w_size_ok  = (img_width >= MIN_SZ) && (img_height >= MIN_SZ) && (img_width <= W_MAX);
   assign w_col_idx  = COL_AW'(r_col);
   assign w_line0_rd = r_line0[w_col_idx];
   assign w_line1_rd = r_line1[w_col_idx];

   // Line memories shift one row down per accepted pixel; contents need no reset
   // because rows 0 and 1 of every frame overwrite them before they are read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_line0[w_col_idx] <= w_line1_rd;
         r_line1[w_col_idx] <= pix_data;
      end
   end

   // Frame FSM, counters, column output registers and patch tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_width       <= '0;
         r_height      <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_load_row    <= '0;
         r_load_col    <= '0;
         r_act_load    <= 1'b0;
         r_patch_valid <= 1'b0;
         r_patch_row   <= '0;
         r_patch_col   <= '0;
         r_first_row   <= '0;
         r_second_row  <= '0;
         r_third_row   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_act_load    <= 1'b0;
         r_done        <= 1'b0;
         r_cfg_err     <= 1'b0;
         r_patch_valid <= r_act_load && (r_load_col >= TWO);
         // Coordinates follow the load that completes the window, one cycle later.
         if (r_act_load && (r_load_col >= TWO)) begin
            r_patch_row <= r_load_row - TWO;
            r_patch_col <= r_load_col - TWO;
         end else begin
            r_patch_row <= r_patch_row;
            r_patch_col <= r_patch_col;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_size_ok) begin
                     r_width  <= img_width;
                     r_height <= img_height;
                     r_col    <= '0;
                     r_row    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_RUN;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  // Rows 0 and 1 only prime the line memories.
                  if (r_row >= TWO) begin
                     r_act_load   <= 1'b1;
                     r_first_row  <= w_line0_rd;
                     r_second_row <= w_line1_rd;
                     r_third_row  <= pix_data;
                     r_load_row   <= r_row;
                     r_load_col   <= r_col;
                  end
                  if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + ONE;
                  end else begin
                     r_col <= r_col + ONE;
                  end
                  if (w_last_col && w_last_row) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign act_load        = r_act_load;
   assign data_first_row  = r_first_row;
   assign data_second_row = r_second_row;
   assign data_third_row  = r_third_row;
   assign patch_valid     = r_patch_valid;
   assign patch_row       = r_patch_row;
   assign patch_col       = r_patch_col;
   assign busy            = r_busy;
   assign done            = r_done;
   assign cfg_err         = r_cfg_err;

endmodule
